// File: rtl/mipi_csi_pkg.sv
// rtl/mipi_csi_pkg.sv - CSI-2 TX constants, header ECC function and encoder state enum
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_YUV422_8 = 6'h1E;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam logic [7:0]  SYNC_BYTE  = 8'hB8;
    localparam logic [15:0] CRC_SEED   = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_R = 16'h8408;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_CRC,
        ST_GAP
    } csi_state_t;

    // d = {WC_hi, WC_lo, DI}; each mask selects the data bits feeding one parity bit
    function automatic logic [7:0] csi_ecc6(input logic [23:0] d);
        csi_ecc6 = {2'b00,
                    ^(d & 24'hEFFC00),
                    ^(d & 24'hDF03F0),
                    ^(d & 24'hB8E38E),
                    ^(d & 24'h749A6D),
                    ^(d & 24'hF2555B),
                    ^(d & 24'hF12CB7)};
    endfunction

endpackage

// File: rtl/mipi_csi_crc16_2b.sv
// rtl/mipi_csi_crc16_2b.sv - reflected CRC-16 (0x8408) absorbing two bytes per cycle, low byte first
module mipi_csi_crc16_2b
    import mipi_csi_pkg::*;
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            crc_o <= CRC_SEED;
        end else if (clear_i) begin
            crc_o <= CRC_SEED;
        end else if (enable_i) begin
            crc_o <= crc_byte(crc_byte(crc_o, data_i[7:0]), data_i[15:8]);
        end
    end

endmodule

// File: rtl/mipi_csi_tx_packet_encoder_8b2lane.sv
// rtl/mipi_csi_tx_packet_encoder_8b2lane.sv - CSI-2 2-lane packet encoder; CSI_TX_CRC_EN enables the payload CRC
module mipi_csi_tx_packet_encoder_8b2lane
    import mipi_csi_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4
)
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_vc_i,
    input  logic [5:0]  cmd_dt_i,
    input  logic [15:0] cmd_wc_i,
    input  logic        pld_valid_i,
    output logic        pld_ready_o,
    input  logic [15:0] pld_data_i,
    output logic [7:0]  lane0_data_o,
    output logic [7:0]  lane1_data_o,
    output logic        hs_valid_o,
    output logic        busy_o,
    output logic        pkt_done_o,
    output logic        err_o
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    csi_state_t  state, state_n;
    logic [1:0]  vc_q;
    logic [5:0]  dt_q;
    logic [15:0] wc_q;
    logic [16:0] rem_q, rem_n;
    logic [7:0]  gap_q, gap_n;
    logic [7:0]  lane0_n, lane1_n;
    logic        hs_valid_n, pkt_done_n, err_n;
    logic        accept, is_long;
    logic [16:0] pld_len;
    logic [15:0] pld_word;
    logic [15:0] crc;
    logic [7:0]  di, ecc;

    assign cmd_ready_o = (state == ST_IDLE) && !wb_rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state != ST_IDLE);
    assign is_long     = (dt_q >= DT_LONG_MIN);
    // odd word counts are padded to an even byte count on the wire
    assign pld_len     = {1'b0, wc_q} + {16'd0, wc_q[0]};
    assign pld_word    = pld_valid_i ? pld_data_i : 16'h0000;
    assign di          = {vc_q, dt_q};
    assign ecc         = csi_ecc6({wc_q, di});

    // A word is taken on the edge that puts it on the lanes, so HDR1 already pulls the first one
    assign pld_ready_o = ((state == ST_HDR1) && is_long && (wc_q != 16'd0)) ||
                         ((state == ST_PAYLOAD) && (rem_q != 17'd0));

`ifdef CSI_TX_CRC_EN
    mipi_csi_crc16_2b u_crc (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear_i  (accept),
        .enable_i (pld_ready_o),
        .data_i   (pld_word),
        .crc_o    (crc)
    );
`else
    assign crc = 16'h0000;
`endif

    always_comb begin
        state_n    = state;
        rem_n      = rem_q;
        gap_n      = gap_q;
        lane0_n    = 8'h00;
        lane1_n    = 8'h00;
        hs_valid_n = 1'b0;
        pkt_done_n = 1'b0;
        err_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n    = ST_SYNC;
                    lane0_n    = SYNC_BYTE;
                    lane1_n    = SYNC_BYTE;
                    hs_valid_n = 1'b1;
                    err_n      = (cmd_dt_i >= DT_LONG_MIN) && cmd_wc_i[0];
                end
            end
            ST_SYNC: begin
                state_n    = ST_HDR0;
                lane0_n    = di;
                lane1_n    = wc_q[7:0];
                hs_valid_n = 1'b1;
            end
            ST_HDR0: begin
                state_n    = ST_HDR1;
                lane0_n    = wc_q[15:8];
                lane1_n    = ecc;
                hs_valid_n = 1'b1;
            end
            ST_HDR1: begin
                if (!is_long) begin
                    state_n    = ST_GAP;
                    gap_n      = GAP_LAST;
                    pkt_done_n = 1'b1;
                end else if (wc_q == 16'd0) begin
                    state_n    = ST_CRC;
                    lane0_n    = crc[7:0];
                    lane1_n    = crc[15:8];
                    hs_valid_n = 1'b1;
                end else begin
                    state_n    = ST_PAYLOAD;
                    rem_n      = pld_len - 17'd2;
                    lane0_n    = pld_word[7:0];
                    lane1_n    = pld_word[15:8];
                    hs_valid_n = 1'b1;
                    err_n      = !pld_valid_i;
                end
            end
            ST_PAYLOAD: begin
                hs_valid_n = 1'b1;
                if (rem_q != 17'd0) begin
                    rem_n   = rem_q - 17'd2;
                    lane0_n = pld_word[7:0];
                    lane1_n = pld_word[15:8];
                    err_n   = !pld_valid_i;
                end else begin
                    state_n = ST_CRC;
                    lane0_n = crc[7:0];
                    lane1_n = crc[15:8];
                end
            end
            ST_CRC: begin
                state_n    = ST_GAP;
                gap_n      = GAP_LAST;
                pkt_done_n = 1'b1;
            end
            ST_GAP: begin
                if (gap_q == 8'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_q - 8'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= ST_IDLE;
            vc_q         <= 2'd0;
            dt_q         <= 6'd0;
            wc_q         <= 16'd0;
            rem_q        <= 17'd0;
            gap_q        <= 8'd0;
            lane0_data_o <= 8'h00;
            lane1_data_o <= 8'h00;
            hs_valid_o   <= 1'b0;
            pkt_done_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_n;
            rem_q        <= rem_n;
            gap_q        <= gap_n;
            lane0_data_o <= lane0_n;
            lane1_data_o <= lane1_n;
            hs_valid_o   <= hs_valid_n;
            pkt_done_o   <= pkt_done_n;
            err_o        <= err_n;
            if (accept) begin
                vc_q <= cmd_vc_i;
                dt_q <= cmd_dt_i;
                wc_q <= cmd_wc_i;
            end
        end
    end

endmodule

// File: tb/tb_mipi_csi_tx_packet_encoder_8b2lane.sv
// tb/tb_mipi_csi_tx_packet_encoder_8b2lane.sv - scoreboard bench for the CSI-2 TX packet encoder
module tb_mipi_csi_tx_packet_encoder_8b2lane;

    localparam int GAP = 4;

    typedef struct packed {
        logic [7:0] l0;
        logic [7:0] l1;
        logic       err;
    } exp_t;

    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid_i, cmd_ready_o;
    logic [1:0]  cmd_vc_i;
    logic [5:0]  cmd_dt_i;
    logic [15:0] cmd_wc_i;
    logic        pld_valid_i, pld_ready_o;
    logic [15:0] pld_data_i;
    logic [7:0]  lane0_data_o, lane1_data_o;
    logic        hs_valid_o, busy_o, pkt_done_o, err_o;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [7:0]  pld_bytes[$];
    logic [15:0] pld_mem[0:15];

    always #5 wb_clk_i = ~wb_clk_i;

    mipi_csi_tx_packet_encoder_8b2lane #(.GAP_CYCLES(GAP)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_vc_i     (cmd_vc_i),
        .cmd_dt_i     (cmd_dt_i),
        .cmd_wc_i     (cmd_wc_i),
        .pld_valid_i  (pld_valid_i),
        .pld_ready_o  (pld_ready_o),
        .pld_data_i   (pld_data_i),
        .lane0_data_o (lane0_data_o),
        .lane1_data_o (lane1_data_o),
        .hs_valid_o   (hs_valid_o),
        .busy_o       (busy_o),
        .pkt_done_o   (pkt_done_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ecc_model(input logic [23:0] d);
        logic [5:0] s;
        s = 6'h00;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) s = s ^ ECC_COL[i];
        end
        return {2'b00, s};
    endfunction

    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (pld_bytes[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ pld_bytes[k][i];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic do_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input int drop_idx, input int abort_at);
        logic        long_pkt;
        logic [7:0]  di;
        logic [15:0] w, crc;
        int          nw, wi, cyc;
        exp_t        e;
        long_pkt = (dt >= 6'h10);
        di       = {vc, dt};
        nw       = long_pkt ? (int'(wc) + 1) / 2 : 0;
        exp_q.delete();
        pld_bytes.delete();
        e = '{8'hB8, 8'hB8, long_pkt && wc[0]};
        exp_q.push_back(e);
        e = '{di, wc[7:0], 1'b0};
        exp_q.push_back(e);
        e = '{wc[15:8], ecc_model({wc, di}), 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < nw; i++) begin
            w = (i == drop_idx) ? 16'h0000 : pld_mem[i];
            pld_bytes.push_back(w[7:0]);
            pld_bytes.push_back(w[15:8]);
            e = '{w[7:0], w[15:8], i == drop_idx};
            exp_q.push_back(e);
        end
        if (long_pkt) begin
`ifdef CSI_TX_CRC_EN
            crc = crc_model();
`else
            crc = 16'h0000;
`endif
            e = '{crc[7:0], crc[15:8], 1'b0};
            exp_q.push_back(e);
        end

        @(negedge wb_clk_i);
        cmd_valid_i = 1'b1;
        cmd_vc_i    = vc;
        cmd_dt_i    = dt;
        cmd_wc_i    = wc;
        cyc = 0;
        while (!cmd_ready_o && cyc < 50) begin
            @(negedge wb_clk_i);
            cyc++;
        end
        chk("cmd_wait_timeout", cyc < 50, 1'b1);
        chk("cmd_ready_accept", cmd_ready_o, 1'b1);
        wi = 0;
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge wb_clk_i);
            cmd_valid_i = 1'b0;
            if (abort_at == cyc) begin
                #2 wb_rst_i = 1'b1;
                #1;
                chk("rst_hs_valid", hs_valid_o, 1'b0);
                chk("rst_lane0", lane0_data_o, 8'h00);
                chk("rst_lane1", lane1_data_o, 8'h00);
                chk("rst_busy", busy_o, 1'b0);
                chk("rst_cmd_ready", cmd_ready_o, 1'b0);
                chk("rst_pld_ready", pld_ready_o, 1'b0);
                exp_q.delete();
                pld_valid_i = 1'b0;
                @(negedge wb_clk_i);
                wb_rst_i = 1'b0;
                return;
            end
            e = exp_q.pop_front();
            chk("hs_valid", hs_valid_o, 1'b1);
            chk("busy", busy_o, 1'b1);
            chk("lane0", lane0_data_o, e.l0);
            chk("lane1", lane1_data_o, e.l1);
            chk("err", err_o, e.err);
            pld_data_i  = pld_mem[wi];
            pld_valid_i = (wi != drop_idx);
            if (pld_ready_o) wi++;
            cyc++;
        end
        pld_valid_i = 1'b0;
        chk("pld_words", wi, nw);
        @(negedge wb_clk_i);
        chk("gap_hs_valid", hs_valid_o, 1'b0);
        chk("pkt_done_pulse", pkt_done_o, 1'b1);
        chk("gap_lane0", lane0_data_o, 8'h00);
        for (int g = 1; g < GAP; g++) begin
            @(negedge wb_clk_i);
            chk("gap_pkt_done", pkt_done_o, 1'b0);
            chk("gap_hold", {hs_valid_o, cmd_ready_o, err_o}, 3'b000);
        end
        @(negedge wb_clk_i);
        chk("idle_ready", cmd_ready_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        logic [15:0] vec [12];
        vec = '{16'h00FF, 16'h0200, 16'hDCB9, 16'h72F3, 16'hD4BB, 16'h5AB8,
                16'h75C8, 16'h7CC2, 16'hF881, 16'hDF05, 16'h00FF, 16'h0100};
        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_vc_i    = 2'd0;
        cmd_dt_i    = 6'd0;
        cmd_wc_i    = 16'd0;
        pld_valid_i = 1'b0;
        pld_data_i  = 16'h0000;
        for (int i = 0; i < 16; i++) pld_mem[i] = 16'h0000;
        repeat (2) @(negedge wb_clk_i);
        chk("reset_outputs", {lane0_data_o, lane1_data_o, hs_valid_o, busy_o, pkt_done_o, err_o, pld_ready_o}, 23'd0);
        chk("reset_cmd_ready", cmd_ready_o, 1'b0);
        wb_rst_i = 1'b0;

        do_packet(2'd0, 6'h00, 16'h0000, -1, -1);
        do_packet(2'd0, 6'h01, 16'h0000, -1, -1);
        do_packet(2'd3, 6'h02, 16'h1234, -1, -1);

        for (int i = 0; i < 12; i++) pld_mem[i] = vec[i];
        do_packet(2'd0, 6'h2A, 16'd24, -1, -1);

        do_packet(2'd0, 6'h2A, 16'd0, -1, -1);

        for (int i = 0; i < 16; i++) pld_mem[i] = 16'(32'h1357 * (i + 3));
        do_packet(2'd1, 6'h1E, 16'd8, 1, -1);

        do_packet(2'd2, 6'h2B, 16'd5, -1, -1);

        do_packet(2'd0, 6'h2A, 16'd8, -1, 5);
        do_packet(2'd0, 6'h00, 16'h0000, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mipi_csi_tx_packet_encoder_8b2lane.md
# mipi_csi_tx_packet_encoder_8b2lane

Transmit-side MIPI CSI-2 packet encoder for two lanes at 8 bits per lane, in the byte-clock domain. It accepts packet commands and a 16-bit payload stream, and emits sync byte, packet header (DI, WC, ECC), payload and CRC-16 footer interleaved across two byte lanes. It sits between the ISP output formatter and the HS serializer / LVDS driver macros. It is the loop-back counterpart of the CSI-2 RX packet decoder used for sensor input.

## Interface
- `GAP_CYCLES`, default 4: idle cycles (`hs_valid_o`=0) forced after every packet; legal range 1–255.
- `wb_clk_i`  in  1: byte clock; all logic on its rising edge.
- `wb_rst_i`  in  1: reset, asynchronous, active-high.
- `cmd_valid_i`  in  1: packet command valid.
- `cmd_ready_o`  out  1: command accepted when `cmd_valid_i` and `cmd_ready_o` are both high.
- `cmd_vc_i`  in  2: virtual channel.
- `cmd_dt_i`  in  6: data type. Values below 0x10 are short packets; 0x10 and above are long packets.
- `cmd_wc_i`  in  16: word count for long packets (bytes), or the data field for short packets.
- `pld_valid_i`  in  1: payload word valid.
- `pld_ready_o`  out  1: payload word consumed this cycle.
- `pld_data_i`  in  16: payload; `[7:0]` is the earlier byte (lane 0), `[15:8]` goes to lane 1.
- `lane0_data_o`  out  8: lane 0 byte.
- `lane1_data_o`  out  8: lane 1 byte.
- `hs_valid_o`  out  1: both lanes carry valid HS bytes.
- `busy_o`  out  1: state is not IDLE.
- `pkt_done_o`  out  1: one-cycle pulse on the first GAP cycle.
- `err_o`  out  1: one-cycle pulse on payload underrun or on an odd long-packet WC.

## Operation
- The DI byte is {`vc`, `dt`}.
- ECC is the CSI-2 v1.x 6-bit Hamming code over {WC_hi, WC_lo, DI} (24 bits, DI bit 0 = D0). ECC bits [7:6] are 0.
- FSM states: IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC, GAP.
  - IDLE: `cmd_ready_o`=1. On accept, latch vc/dt/wc and go to SYNC.
  - SYNC: both lanes 0xB8 → HDR0.
  - HDR0: lane0=DI, lane1=WC[7:0] → HDR1.
  - HDR1: lane0=WC[15:8], lane1=ECC. Next state: GAP if short; CRC if long with WC=0; otherwise PAYLOAD.
  - PAYLOAD: `pld_ready_o`=1. Emit `pld_data_i` bytes; the remaining count drops by 2 per cycle. At the last word → CRC.
  - CRC: lane0=crc[7:0], lane1=crc[15:8] → GAP.
  - GAP: `hs_valid_o`=0 for `GAP_CYCLES` cycles → IDLE.
- Payload underrun: in PAYLOAD with `pld_valid_i`=0, the block still advances and sends 0x00/0x00. That zero data is included in the CRC, and `err_o` pulses. The HS burst is never stalled.
- Odd long-packet WC: the transmitted header keeps the original WC, but the payload length used is WC+1 (last lane-1 byte is padding and is included in the CRC), and `err_o` pulses on accept.
- CRC-16: polynomial x^16+x^12+x^5+1, reflected (0x8408), LSB-first, seed 0xFFFF, no final XOR. It covers payload bytes only, processed two bytes per cycle with lane 0 first.

## Timing
- Outputs are registered. A command accepted at edge N puts SYNC on the outputs in cycle N+1.
- Packet lengths on `hs_valid_o`:
  - short packet: 3 cycles;
  - long packet: 4 + WC/2 cycles.
- Next accept is possible `GAP_CYCLES` cycles after `hs_valid_o` falls.
- `cmd_ready_o` is combinational from state and is 0 while `wb_rst_i` is high.
- Reset values: all lanes 0x00; `hs_valid_o`, `busy_o`, `pkt_done_o`, `err_o`, `pld_ready_o` = 0.
- Reset mid-packet: abort immediately to IDLE. No footer is sent, and the packet counters and CRC are reseeded.
- A command presented during a packet is held off by `cmd_ready_o`=0. It is not lost.

## Configuration
- `CSI_TX_CRC_EN` defined: CRC computed as above.
- `CSI_TX_CRC_EN` undefined: the CRC sub-module is not instantiated and the footer is 0x0000 (CSI-2 "checksum not computed"). All timing is identical.

## Structure
- Package `mipi_csi_pkg` holds:
  - data-type constants (FS 0x00, FE 0x01, LS 0x02, LE 0x03, YUV422_8 0x1E, RAW8 0x2A, RAW10 0x2B);
  - SYNC_BYTE 0xB8, CRC_SEED 0xFFFF, CRC_POLY_R 0x8408;
  - the `csi_ecc6` function;
  - the state enum.
- Sub-module `mipi_csi_crc16_2b`: 16-bit CRC updated with two bytes per cycle, with clear and enable inputs.

## Test plan
- FS short packet (VC0, DT 0x00, WC 0x0000) → lanes show B8/B8, 00/00, 00/00 (ECC 0x00). Then 4 idle cycles, and `pkt_done_o` pulses once.
- FE short packet (DT 0x01, WC 0x0000) → HDR1 lane1 ECC = 0x07.
- Long packet, DT 0x2A, WC 24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → footer lane0 0xF0, lane1 0x00, with 16 `hs_valid_o` cycles.
- Long packet with WC 0 → SYNC, HDR0, HDR1, then footer FF/FF. Undefined `CSI_TX_CRC_EN` → footer 00/00.
- `pld_valid_i` dropped for 1 cycle in a WC 8 packet → 00/00 emitted, `err_o` pulses, burst length unchanged (8 cycles).
- `wb_rst_i` asserted during PAYLOAD → `hs_valid_o`=0 the same cycle. The next FS packet after release is byte-exact.
